my_mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares one my_mem instance: 8-bit data, 16-bit address, 9-bit read data with the parity bit in bit 8.
- Turns each requester's single-word read or write command into correctly timed mem_write/mem_read pulses.
- Captures the read data, checks its parity and returns the result to the winning requester with a one-cycle ack.
- Sits between the processing clients and the memory; it is the only driver of the memory's control pins.

---
 rtl/my_mem_arbiter_if.sv | 44 ++++
 rtl/my_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_my_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_mem_arbiter_if.sv
// my_mem_arbiter_if
//   Bundles the requester handshake signals and the memory control bus used by
//   my_mem_arbiter. Signal names match the arbiter's original port names.
//   Parameters: ADDR_W (address width), DATA_W (data width; the memory read bus
//   is DATA_W+1 bits with parity in the top bit).
//   Modports:
//     master - the arbiter: takes requests and read data, drives acks/status/memory pins
//     slave  - the environment: requesters plus the memory
interface my_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              perr;
  logic [7:0]        err_count;
  logic              busy;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W:0]   mem_data_out;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata, perr, err_count, busy,
           mem_write, mem_read, mem_address, mem_data_in
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata, perr, err_count, busy,
           mem_write, mem_read, mem_address, mem_data_in
  );
endinterface

// File: rtl/my_mem_arbiter.sv
// my_mem_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single my_mem.
//   Each requester issues one single-word read or write; the arbiter turns it
//   into a one-cycle mem_write/mem_read pulse, waits RD_LAT cycles for read
//   data, and returns the result with a one-cycle ack to the granted port.
//   Ports:
//     clk, rst_n  - clock (rising edge), asynchronous active-low reset
//     bus         - my_mem_arbiter_if.master: req/we/addr/wdata per port in,
//                   ack per port, rdata/perr/err_count/busy out, memory pins
//   Parameters: ADDR_W, DATA_W, RD_LAT (1..4 cycles mem_read -> valid data).
//   Build option: define MY_MEM_PARITY_CHECK_EN to enable even-parity checking
//   of read data (perr, saturating err_count); otherwise both are tied to 0.
module my_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  my_mem_arbiter_if.master  bus
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant;
  logic              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              grant_vld;
  logic              grant_port;
  logic              cnt_load;
  logic              capture;

  // Next state and per-cycle strobes
  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    cnt_load   = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          // Tie goes to the port that did not win last time.
          grant_vld  = 1'b1;
          grant_port = ~last_grant;
        end else if (bus.req0) begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end else if (bus.req1) begin
          grant_vld  = 1'b1;
          grant_port = 1'b1;
        end
        if (grant_vld) state_d = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        gnt_q      <= grant_port;
        last_grant <= grant_port;
        we_q       <= grant_port ? bus.we1    : bus.we0;
        addr_q     <= grant_port ? bus.addr1  : bus.addr0;
        wdata_q    <= grant_port ? bus.wdata1 : bus.wdata0;
        // Cleared here so a write acks with rdata = 0.
        rdata_q    <= '0;
      end
      if (cnt_load) begin
        cnt_q <= CNT_W'(RD_LAT);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) rdata_q <= bus.mem_data_out[DATA_W-1:0];
    end
  end

`ifdef MY_MEM_PARITY_CHECK_EN
  logic       perr_q;
  logic [7:0] err_cnt_q;
  logic       par_bad;

  // Even parity over data plus parity bit: any odd XOR is an error.
  assign par_bad = ^bus.mem_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else if (grant_vld) begin
      perr_q <= 1'b0;
    end else if (capture) begin
      perr_q <= par_bad;
      // Counted at capture so err_count already reflects this read during its ack.
      if (par_bad && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.perr      = perr_q;
  assign bus.err_count = err_cnt_q;
`else
  assign bus.perr      = 1'b0;
  assign bus.err_count = '0;
`endif

  // Control pins decode straight from state so an async reset drops them at once.
  assign bus.ack0        = (state_q == DONE) && !gnt_q;
  assign bus.ack1        = (state_q == DONE) &&  gnt_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_write   = (state_q == ACCESS) &&  we_q;
  assign bus.mem_read    = (state_q == ACCESS) && !we_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_my_mem_arbiter.sv
// tb_my_mem_arbiter
//   Directed bench for my_mem_arbiter. Two instances: g_dut[0] with RD_LAT=1
//   and g_dut[1] with RD_LAT=3, each with its own memory model that presents
//   read data only in the cycle RD_LAT after mem_read (garbage otherwise) and
//   stores a deliberately wrong parity bit for address 16'hBEEF.
module tb_my_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

`ifdef MY_MEM_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2];
  logic          perr  [2];
  logic [7:0]    err_count [2];
  logic          busy  [2];
  logic          mem_write [2];
  logic          mem_read  [2];
  logic [AW-1:0] mem_address [2];

  int n_cmp = 0;
  int n_mis = 0;
  int order_q[$];

  for (genvar D = 0; D < 2; D++) begin : g_dut
    localparam int LAT = (D == 0) ? 1 : 3;

    my_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bi ();

    assign bi.req0   = req[D][0];
    assign bi.req1   = req[D][1];
    assign bi.we0    = we[D][0];
    assign bi.we1    = we[D][1];
    assign bi.addr0  = addr[D][0];
    assign bi.addr1  = addr[D][1];
    assign bi.wdata0 = wdata[D][0];
    assign bi.wdata1 = wdata[D][1];
    assign ack[D][0]      = bi.ack0;
    assign ack[D][1]      = bi.ack1;
    assign rdata[D]       = bi.rdata;
    assign perr[D]        = bi.perr;
    assign err_count[D]   = bi.err_count;
    assign busy[D]        = bi.busy;
    assign mem_write[D]   = bi.mem_write;
    assign mem_read[D]    = bi.mem_read;
    assign mem_address[D] = bi.mem_address;

    my_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n[D]),
      .bus   (bi)
    );

    // Memory model
    logic [DW:0]   mem [0:65535];
    logic [DW:0]   rword = '0;
    int            mcnt  = 0;

    always @(posedge clk) begin
      if (bi.mem_write)
        mem[bi.mem_address] <= {(bi.mem_address == 16'hBEEF) ? ~(^bi.mem_data_in)
                                                             :  (^bi.mem_data_in),
                                bi.mem_data_in};
      if (bi.mem_read) begin
        rword <= mem[bi.mem_address];
        mcnt  <= LAT;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end

    assign bi.mem_data_out = (mcnt == 1) ? rword : 9'h1A5;

    // Activity monitors
    int wr_n = 0, rd_n = 0, both_n = 0, ack_n = 0;
    always @(negedge clk) begin
      if (bi.mem_write) wr_n <= wr_n + 1;
      if (bi.mem_read)  rd_n <= rd_n + 1;
      if (bi.mem_write && bi.mem_read) both_n <= both_n + 1;
      if (bi.ack0 || bi.ack1) ack_n <= ack_n + 1;
    end

    if (D == 0) begin : g_log
      always @(negedge clk) begin
        if (bi.ack0) order_q.push_back(0);
        if (bi.ack1) order_q.push_back(1);
      end
    end
  end

  function automatic int get_wr(input int d);
    return (d == 0) ? g_dut[0].wr_n : g_dut[1].wr_n;
  endfunction
  function automatic int get_rd(input int d);
    return (d == 0) ? g_dut[0].rd_n : g_dut[1].rd_n;
  endfunction
  function automatic int get_both(input int d);
    return (d == 0) ? g_dut[0].both_n : g_dut[1].both_n;
  endfunction
  function automatic int get_acks(input int d);
    return (d == 0) ? g_dut[0].ack_n : g_dut[1].ack_n;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Starts at posedge+1 of the cycle the request is first seen; lat is the
  // number of cycles from that cycle to the ack cycle (-1 on timeout).
  task automatic req_op(input int d, input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int lat,
                        output logic [DW-1:0] rd, output logic pe);
    we[d][p]    = w;
    addr[d][p]  = a;
    wdata[d][p] = wd;
    req[d][p]   = 1'b1;
    lat = -1;
    rd  = '0;
    pe  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ack[d][p]) begin
        lat = k;
        rd  = rdata[d];
        pe  = perr[d];
        break;
      end
    end
    @(posedge clk);
    #1;
    req[d][p] = 1'b0;
  endtask

  task automatic op_chk(input int d, input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int exp_lat,
                        input logic [DW-1:0] exp_rd, input string tag);
    int            lat;
    logic [DW-1:0] rd;
    logic          pe;
    req_op(d, p, w, a, wd, lat, rd, pe);
    check_val({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check_val({tag, "_rdata"}, 32'(rd),  32'(exp_rd));
    check_val({tag, "_perr"},  32'(pe),  32'd0);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            l0, l1, a0;
    logic [DW-1:0] r0, r1;
    logic          e0, e1;
    logic [DW-1:0] sb [16];

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack0",      32'(ack[0][0]),      0);
    check_val("rst_ack1",      32'(ack[0][1]),      0);
    check_val("rst_busy",      32'(busy[0]),        0);
    check_val("rst_mem_write", 32'(mem_write[0]),   0);
    check_val("rst_mem_read",  32'(mem_read[0]),    0);
    check_val("rst_mem_addr",  32'(mem_address[0]), 0);
    check_val("rst_rdata",     32'(rdata[0]),       0);
    check_val("rst_err_count", 32'(err_count[0]),   0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;

    // Port 0 write then read back, RD_LAT=1
    op_chk(0, 0, 1'b1, 16'h1234, 8'hA5, 2, 8'h00, "t1_wr");
    check_val("t1_wr_pulses", 32'(get_wr(0)), 1);
    op_chk(0, 0, 1'b0, 16'h1234, 8'h00, 3, 8'hA5, "t1_rd");
    check_val("t1_rd_pulses", 32'(get_rd(0)), 1);
    check_val("t1_wr_pulses_after_rd", 32'(get_wr(0)), 1);

    // Simultaneous requests straight after reset: port 0 wins the first tie
    do_reset(0);
    order_q.delete();
    fork
      req_op(0, 0, 1'b1, 16'h0001, 8'h11, l0, r0, e0);
      req_op(0, 1, 1'b1, 16'h0002, 8'h22, l1, r1, e1);
    join
    check_val("t2_lat_p0", 32'(l0), 2);
    check_val("t2_lat_p1", 32'(l1), 5);
    check_val("t2_first",  32'(order_q[0]), 0);
    check_val("t2_second", 32'(order_q[1]), 1);
    op_chk(0, 0, 1'b0, 16'h0001, 8'h00, 3, 8'h11, "t2_rb1");
    op_chk(0, 0, 1'b0, 16'h0002, 8'h00, 3, 8'h22, "t2_rb2");

    // Continuous contention: port 0 won last, so port 1 leads and grants alternate
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int l; logic [DW-1:0] r; logic e;
          req_op(0, 0, 1'b0, 16'h0001, 8'h00, l, r, e);
          check_val("t3_wait_p0",  32'(l >= 3 && l <= 7), 1);
          check_val("t3_rdata_p0", 32'(r), 32'h11);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          int l; logic [DW-1:0] r; logic e;
          req_op(0, 1, 1'b0, 16'h0002, 8'h00, l, r, e);
          check_val("t3_wait_p1",  32'(l >= 3 && l <= 7), 1);
          check_val("t3_rdata_p1", 32'(r), 32'h22);
        end
      end
    join
    check_val("t3_order_len", 32'(order_q.size()), 12);
    for (int i = 0; i < 12 && i < order_q.size(); i++)
      check_val("t3_order", 32'(order_q[i]), 32'((i + 1) % 2));

    // Forced parity error at 16'hBEEF
    check_val("t4_errcnt_before", 32'(err_count[0]), 0);
    op_chk(0, 0, 1'b1, 16'hBEEF, 8'h3C, 2, 8'h00, "t4_wr");
    req_op(0, 0, 1'b0, 16'hBEEF, 8'h00, l0, r0, e0);
    check_val("t4_lat",   32'(l0), 3);
    check_val("t4_rdata", 32'(r0), 32'h3C);
    check_val("t4_perr",  32'(e0), 32'(PAR_EN));
    check_val("t4_errcnt_after", 32'(err_count[0]), 32'(PAR_EN));

    // Reset during WAIT of a read on the RD_LAT=3 instance
    op_chk(1, 0, 1'b1, 16'h0100, 8'h5A, 2, 8'h00, "t5_wr");
    we[1][0] = 1'b0; addr[1][0] = 16'h0100; req[1][0] = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t5_busy_in_wait", 32'(busy[1]), 1);
    #1;
    rst_n[1] = 1'b0;
    #1;
    check_val("t5_rst_mem_read", 32'(mem_read[1]), 0);
    check_val("t5_rst_ack",      32'(ack[1][0]),   0);
    check_val("t5_rst_busy",     32'(busy[1]),     0);
    req[1][0] = 1'b0;
    a0 = get_acks(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    check_val("t5_no_stale_ack", 32'(get_acks(1)), 32'(a0));
    check_val("t5_idle_after",   32'(busy[1]),     0);
    check_val("t5_addr_cleared", 32'(mem_address[1]), 0);
    @(posedge clk);
    #1;
    op_chk(1, 0, 1'b0, 16'h0100, 8'h00, 5, 8'h5A, "t5_retry");

    // RD_LAT=3, port 1
    op_chk(1, 1, 1'b1, 16'hFFFF, 8'h7E, 2, 8'h00, "t6_wr");
    op_chk(1, 1, 1'b0, 16'hFFFF, 8'h00, 5, 8'h7E, "t6_rd");

    // Random mixed traffic against a scoreboard
    for (int i = 0; i < 16; i++) begin
      sb[i] = 8'($urandom);
      op_chk(1, i % 2, 1'b1, 16'h4000 + 16'(i), sb[i], 2, 8'h00, "t7_init");
    end
    for (int n = 0; n < 300; n++) begin
      int            p, i;
      logic          w;
      logic [DW-1:0] wd;
      p  = int'($urandom_range(0, 1));
      i  = int'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      if (w) begin
        op_chk(1, p, 1'b1, 16'h4000 + 16'(i), wd, 2, 8'h00, "t7_wr");
        sb[i] = wd;
      end else begin
        op_chk(1, p, 1'b0, 16'h4000 + 16'(i), 8'h00, 5, sb[i], "t7_rd");
      end
    end
    check_val("t7_errcnt", 32'(err_count[1]), 0);

    check_val("never_both_0", 32'(get_both(0)), 0);
    check_val("never_both_1", 32'(get_both(1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
